// File: rtl/game_state_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : game_state_uart_tx
// Description : Serialises a snapshot of the game state (ball position and
//               both scores) into an 8-byte packet and sends it over a UART
//               line, 8N1, LSB first. The packet is a sync header, six
//               payload bytes and an XOR checksum of the payload bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module game_state_uart_tx #(
  parameter int           CLKS_PER_BIT = 564,
  parameter logic [7:0]   HEADER       = 8'hA5
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        send,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  input  logic [4:0]  player_1_score,
  input  logic [4:0]  player_2_score,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  // Bit-period counter only has to reach CLKS_PER_BIT-1; keep it at least
  // one bit wide so a degenerate CLKS_PER_BIT=1 still elaborates.
  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0] c_last_byte = 3'd7;
  localparam logic [2:0] c_last_bit  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_clk_cnt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          r_byte_idx;

  // Game state captured when a packet is accepted; the packet in flight is
  // built only from these so later input changes cannot corrupt it.
  logic [11:0]         r_x;
  logic [11:0]         r_y;
  logic [4:0]          r_p1;
  logic [4:0]          r_p2;

  logic                r_tx;
  logic                r_busy;
  logic                r_done;

  logic                w_bit_end;
  logic [2:0]          w_next_bit;
  logic [7:0]          w_b1;
  logic [7:0]          w_b2;
  logic [7:0]          w_b3;
  logic [7:0]          w_b4;
  logic [7:0]          w_b5;
  logic [7:0]          w_b6;
  logic [7:0]          w_chk;
  logic [7:0]          w_cur_byte;

  assign w_bit_end  = (r_clk_cnt == c_last_cnt);
  assign w_next_bit = r_bit_idx + 3'd1;

  assign w_b1  = {4'h0, r_x[11:8]};
  assign w_b2  = r_x[7:0];
  assign w_b3  = {4'h0, r_y[11:8]};
  assign w_b4  = r_y[7:0];
  assign w_b5  = {3'b000, r_p1};
  assign w_b6  = {3'b000, r_p2};
  assign w_chk = w_b1 ^ w_b2 ^ w_b3 ^ w_b4 ^ w_b5 ^ w_b6;

  // Select the packet byte addressed by the current byte index.
  always_comb begin
    w_cur_byte = HEADER;
    case (r_byte_idx)
      3'd0:    w_cur_byte = HEADER;
      3'd1:    w_cur_byte = w_b1;
      3'd2:    w_cur_byte = w_b2;
      3'd3:    w_cur_byte = w_b3;
      3'd4:    w_cur_byte = w_b4;
      3'd5:    w_cur_byte = w_b5;
      3'd6:    w_cur_byte = w_b6;
      default: w_cur_byte = w_chk;
    endcase
  end

  // Framing FSM: walks start/data/stop bits for each of the eight bytes and
  // drives the registered line, busy and done outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 3'd0;
      r_x        <= 12'd0;
      r_y        <= 12'd0;
      r_p1       <= 5'd0;
      r_p2       <= 5'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_clk_cnt  <= '0;
          r_bit_idx  <= 3'd0;
          r_byte_idx <= 3'd0;
          if (send) begin
            r_x     <= xpos_ball;
            r_y     <= ypos_ball;
            r_p1    <= player_1_score;
            r_p2    <= player_2_score;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= w_cur_byte[0];
            r_state   <= DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == c_last_bit) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= w_next_bit;
              r_tx      <= w_cur_byte[w_next_bit];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_byte_idx == c_last_byte) begin
              // Packet complete: idle again, so a send in the done cycle
              // is accepted on the very next edge.
              r_byte_idx <= 3'd0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_tx       <= 1'b1;
              r_state    <= IDLE;
            end else begin
              // Next start bit follows the stop bit with no gap.
              r_byte_idx <= r_byte_idx + 3'd1;
              r_tx       <= 1'b0;
              r_state    <= START;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_game_state_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_state_uart_tx
// Description : Directed self-checking bench for game_state_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_state_uart_tx;

  localparam int CPB     = 4;
  localparam int PKT_CYC = 80 * CPB;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        send   = 1'b0;
  logic [11:0] xpos_ball = 12'd0;
  logic [11:0] ypos_ball = 12'd0;
  logic [4:0]  player_1_score = 5'd0;
  logic [4:0]  player_2_score = 5'd0;
  logic        tx;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  // Capture results
  logic       cap_tx [0:PKT_CYC-1];
  logic [7:0] rx_byte [0:7];
  logic [7:0] exp_pkt [0:7];
  int         cap_len;
  int         cap_wait;
  int         cap_done_mid;
  int         cap_frame_err;
  logic       cap_done_end;
  bit         cap_timeout;

  game_state_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .HEADER       (8'hA5)
  ) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .send           (send),
    .xpos_ball      (xpos_ball),
    .ypos_ball      (ypos_ball),
    .player_1_score (player_1_score),
    .player_2_score (player_2_score),
    .tx             (tx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk_in = ~clk_in;

  // Expected packet for x=487 (0x1E7), y=362 (0x16A), p1=3, p2=5
  task automatic set_ref_inputs();
    xpos_ball      = 12'd487;
    ypos_ball      = 12'd362;
    player_1_score = 5'd3;
    player_2_score = 5'd5;
    exp_pkt[0] = 8'hA5; exp_pkt[1] = 8'h01; exp_pkt[2] = 8'hE7; exp_pkt[3] = 8'h01;
    exp_pkt[4] = 8'h6A; exp_pkt[5] = 8'h03; exp_pkt[6] = 8'h05; exp_pkt[7] = 8'h8B;
  endtask

  // Called at a negedge. Waits (bounded) for busy, records tx every cycle
  // while busy, then decodes 8 frames from the recording.
  task automatic capture_packet(input int max_wait);
    int base;
    logic [7:0] v;
    cap_len = 0; cap_wait = 0; cap_done_mid = 0; cap_frame_err = 0;
    cap_timeout = 1'b0; cap_done_end = 1'b0;
    for (int i = 0; i < PKT_CYC; i++) cap_tx[i] = 1'bx;
    while (busy !== 1'b1 && cap_wait < max_wait) begin
      @(negedge clk_in);
      cap_wait++;
    end
    if (busy !== 1'b1) begin
      cap_timeout = 1'b1;
      return;
    end
    while (busy === 1'b1 && cap_len < PKT_CYC + 40) begin
      if (cap_len < PKT_CYC) cap_tx[cap_len] = tx;
      if (done !== 1'b0) cap_done_mid++;
      cap_len++;
      @(negedge clk_in);
    end
    cap_done_end = done;
    for (int b = 0; b < 8; b++) begin
      v = 8'h00;
      for (int j = 0; j < 10; j++) begin
        base = (b * 10 + j) * CPB;
        for (int k = 1; k < CPB; k++)
          if (cap_tx[base + k] !== cap_tx[base]) cap_frame_err++;
        if (j >= 1 && j <= 8) v[j-1] = cap_tx[base];
      end
      if (cap_tx[b * 10 * CPB] !== 1'b0) cap_frame_err++;
      if (cap_tx[(b * 10 + 9) * CPB] !== 1'b1) cap_frame_err++;
      rx_byte[b] = v;
    end
  endtask

  task automatic check_capture(input string tag);
    n_total++;
    if (cap_timeout) $display("FAIL %s_start: busy never rose within bound", tag);
    else n_pass++;
    n_total++;
    if (cap_len !== PKT_CYC) $display("FAIL %s_busy_len: got %0d cycles, expected %0d", tag, cap_len, PKT_CYC);
    else n_pass++;
    n_total++;
    if (cap_frame_err !== 0) $display("FAIL %s_framing: got %0d framing errors, expected 0", tag, cap_frame_err);
    else n_pass++;
    for (int b = 0; b < 8; b++) begin
      n_total++;
      if (rx_byte[b] !== exp_pkt[b])
        $display("FAIL %s_byte%0d: got %02h, expected %02h", tag, b, rx_byte[b], exp_pkt[b]);
      else n_pass++;
    end
    n_total++;
    if (cap_done_mid !== 0) $display("FAIL %s_done_early: got %0d done cycles while busy, expected 0", tag, cap_done_mid);
    else n_pass++;
    n_total++;
    if (cap_done_end !== 1'b1) $display("FAIL %s_done_end: got %b, expected 1", tag, cap_done_end);
    else n_pass++;
  endtask

  // Reset held with send toggling: line idle, no busy, no done
  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      send = ~send;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    send = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL reset_idle: got %0d bad cycles (tx=%b busy=%b done=%b), expected 0", bad, tx, busy, done);
    else n_pass++;
  endtask

  // Single packet with reference inputs; latency checked on the first cycle
  task automatic test_packet();
    set_ref_inputs();
    @(negedge clk_in);
    send = 1'b1;
    @(negedge clk_in);
    send = 1'b0;
    n_total++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL pkt_latency: got tx=%b busy=%b, expected tx=0 busy=1", tx, busy);
    else n_pass++;
    capture_packet(4);
    check_capture("pkt");
    @(negedge clk_in);
    n_total++;
    if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL pkt_after: got done=%b tx=%b busy=%b, expected 0 1 0", done, tx, busy);
    else n_pass++;
  endtask

  // Inputs change right after acceptance; packet must carry the old values
  task automatic test_snapshot();
    set_ref_inputs();
    repeat (3) @(negedge clk_in);
    send = 1'b1;
    @(negedge clk_in);
    send = 1'b0;
    xpos_ball      = 12'd0;
    player_2_score = 5'd31;
    capture_packet(4);
    check_capture("snap");
    set_ref_inputs();
  endtask

  // Sends while busy are ignored; no restart after the packet
  task automatic test_busy_ignore();
    int extra;
    set_ref_inputs();
    repeat (3) @(negedge clk_in);
    send = 1'b1;
    @(negedge clk_in);
    send = 1'b0;
    fork
      capture_packet(4);
      begin
        for (int p = 0; p < 6; p++) begin
          repeat (49) @(negedge clk_in);
          send = 1'b1;
          @(negedge clk_in);
          send = 1'b0;
        end
      end
    join
    check_capture("busy");
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (busy !== 1'b0 || tx !== 1'b1) extra++;
    end
    n_total++;
    if (extra !== 0) $display("FAIL busy_restart: got %0d active cycles after packet, expected 0", extra);
    else n_pass++;
  endtask

  // Send held high: second packet starts the cycle after done
  task automatic test_back_to_back();
    set_ref_inputs();
    @(negedge clk_in);
    send = 1'b1;
    capture_packet(4);
    check_capture("b2b_first");
    n_total++;
    if (tx !== 1'b1) $display("FAIL b2b_gap_tx: got %b in done cycle, expected 1", tx);
    else n_pass++;
    capture_packet(4);
    send = 1'b0;
    n_total++;
    if (cap_wait !== 1) $display("FAIL b2b_restart: got %0d cycles from done to busy, expected 1", cap_wait);
    else n_pass++;
    check_capture("b2b_second");
    repeat (4) @(negedge clk_in);
    n_total++;
    if (busy !== 1'b0) $display("FAIL b2b_stop: got busy=%b, expected 0", busy);
    else n_pass++;
  endtask

  // Reset during byte 3 abandons the packet; a new send gives a full packet
  task automatic test_mid_reset();
    int bad;
    set_ref_inputs();
    @(negedge clk_in);
    send = 1'b1;
    @(negedge clk_in);
    send = 1'b0;
    repeat (32 * CPB) @(negedge clk_in);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_async: got tx=%b busy=%b done=%b, expected 1 0 0", tx, busy, done);
    else n_pass++;
    bad = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk_in);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL midrst_idle: got %0d bad cycles, expected 0", bad);
    else n_pass++;
    send = 1'b1;
    @(negedge clk_in);
    send = 1'b0;
    capture_packet(4);
    check_capture("midrst");
  endtask

  initial begin
    test_reset();
    test_packet();
    test_snapshot();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
